// File: rtl/uart_sram_tx_interface_pkg.sv
// Shared state encodings and baud constant for the UART SRAM transmit path.
// The receive side uses the same bit period.
package uart_sram_tx_interface_pkg;

   // 50 MHz / 115200 baud
   localparam int unsigned UART_CLKS_PER_BIT = 434;
   localparam int unsigned UART_SRAM_READ_LATENCY = 2;

   typedef enum logic [2:0] {
      S_TX_IDLE,
      S_TX_ISSUE_READ,
      S_TX_WAIT_READ,
      S_TX_SEND_HI,
      S_TX_SEND_LO,
      S_TX_DONE
   } tx_state_e;

   typedef enum logic [1:0] {
      S_BIT_IDLE,
      S_BIT_START,
      S_BIT_DATA,
      S_BIT_STOP
   } bit_state_e;

endpackage

// File: rtl/uart_sram_tx_interface_byte_tx.sv
// 8N1 byte serialiser: start bit, 8 data bits LSB first, stop bit.
// A Load during the final stop-bit cycle chains the next frame with no idle gap.
module uart_byte_tx
   import uart_sram_tx_interface_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic       Load,
   input  logic [7:0] Data,
   output logic       TX,
   output logic       Byte_done,
   output logic       Busy
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   bit_state_e      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            bit_end;

   assign bit_end = (cnt_q == CntW'(CLKS_PER_BIT - 1));
   assign Busy    = (state_q != S_BIT_IDLE);

   always_comb begin
      state_d   = state_q;
      cnt_d     = bit_end ? '0 : cnt_q + CntW'(1);
      bit_d     = bit_q;
      shift_d   = shift_q;
      Byte_done = 1'b0;
      unique case (state_q)
         S_BIT_IDLE: begin
            cnt_d = '0;
            if (Load) begin
               shift_d = Data;
               state_d = S_BIT_START;
            end
         end
         S_BIT_START: begin
            if (bit_end) begin
               bit_d   = 3'd0;
               state_d = S_BIT_DATA;
            end
         end
         S_BIT_DATA: begin
            if (bit_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = S_BIT_STOP;
               else               bit_d   = bit_q + 3'd1;
            end
         end
         S_BIT_STOP: begin
            if (bit_end) begin
               Byte_done = 1'b1;
               if (Load) begin
                  shift_d = Data;
                  state_d = S_BIT_START;
               end else begin
                  state_d = S_BIT_IDLE;
               end
            end
         end
         default: state_d = S_BIT_IDLE;
      endcase
   end

   // Line is decoded from state so reset forces it high without a clock edge
   always_comb begin
      TX = 1'b1;
      unique case (state_q)
         S_BIT_START: TX = 1'b0;
         S_BIT_DATA:  TX = shift_q[0];
         default:     TX = 1'b1;
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= S_BIT_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

endmodule

// File: rtl/uart_sram_tx_interface.sv
// Reads a block of 16-bit SRAM words and sends each as two UART bytes, high byte first.
// Shares the SRAM controller with M1/VGA; never writes.
module uart_sram_tx_interface
   import uart_sram_tx_interface_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT      = UART_CLKS_PER_BIT,
   parameter int unsigned SRAM_READ_LATENCY = UART_SRAM_READ_LATENCY
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        Start,
   input  logic        Abort,
   input  logic [17:0] Base_address,
   input  logic [17:0] Word_count,
   output logic [17:0] SRAM_address,
   input  logic [15:0] SRAM_read_data,
   output logic        SRAM_we_n,
   output logic        UART_TX_O,
   output logic        Busy,
   output logic        Done
);

   localparam int unsigned LatW = (SRAM_READ_LATENCY > 1) ? $clog2(SRAM_READ_LATENCY) : 1;

   tx_state_e       state_q, state_d;
   logic [17:0]     addr_q, addr_d;
   logic [17:0]     count_q, count_d;
   logic [15:0]     word_q, word_d;
   logic [LatW-1:0] lat_q, lat_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            ser_load, ser_busy, byte_done;
   logic [7:0]      ser_data;

   uart_byte_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte_tx (
      .Clock    (Clock),
      .Resetn   (Resetn),
      .Load     (ser_load),
      .Data     (ser_data),
      .TX       (UART_TX_O),
      .Byte_done(byte_done),
      .Busy     (ser_busy)
   );

   assign SRAM_address = addr_q;
   assign SRAM_we_n    = 1'b1;
   assign Busy         = busy_q;
   assign Done         = done_q;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      count_d  = count_q;
      word_d   = word_q;
      lat_d    = lat_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      ser_load = 1'b0;
      ser_data = word_q[15:8];
      unique case (state_q)
         S_TX_IDLE: begin
            if (Start) begin
               busy_d  = 1'b1;
               count_d = Word_count;
               // Empty transfer leaves the SRAM address untouched
               if (Word_count == '0) begin
                  state_d = S_TX_DONE;
               end else begin
                  addr_d  = Base_address;
                  state_d = S_TX_ISSUE_READ;
               end
            end
         end
         S_TX_ISSUE_READ: begin
            lat_d   = '0;
            state_d = S_TX_WAIT_READ;
         end
         S_TX_WAIT_READ: begin
            if (lat_q == LatW'(SRAM_READ_LATENCY - 1)) begin
               word_d  = SRAM_read_data;
               addr_d  = addr_q + 18'd1;
               count_d = count_q - 18'd1;
               state_d = S_TX_SEND_HI;
            end else begin
               lat_d = lat_q + LatW'(1);
            end
         end
         S_TX_SEND_HI: begin
            if (!ser_busy) begin
               ser_load = 1'b1;
            end else if (byte_done) begin
               if (Abort) begin
                  state_d = S_TX_DONE;
               end else begin
                  // Chain the low byte into the stop-bit cycle: no gap between halves
                  ser_load = 1'b1;
                  ser_data = word_q[7:0];
                  state_d  = S_TX_SEND_LO;
               end
            end
         end
         S_TX_SEND_LO: begin
            ser_data = word_q[7:0];
            if (byte_done) begin
               if (Abort || count_q == '0) state_d = S_TX_DONE;
               else                         state_d = S_TX_ISSUE_READ;
            end
         end
         S_TX_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_TX_IDLE;
         end
         default: state_d = S_TX_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= S_TX_IDLE;
         addr_q  <= '0;
         count_q <= '0;
         word_q  <= '0;
         lat_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         word_q  <= word_d;
         lat_q   <= lat_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_uart_sram_tx_interface.sv
// Bench for uart_sram_tx_interface: SRAM model with read latency, UART line decoder
// checking every cycle of each frame against bytes queued when a transfer is started.
module tb_uart_sram_tx_interface;

   localparam int unsigned CPB = 434;
   localparam int unsigned LAT = 2;

   logic        Clock = 1'b0;
   logic        Resetn = 1'b0;
   logic        Start = 1'b0;
   logic        Abort = 1'b0;
   logic [17:0] Base_address = '0;
   logic [17:0] Word_count = '0;
   logic [17:0] SRAM_address;
   logic [15:0] SRAM_read_data;
   logic        SRAM_we_n, UART_TX_O, Busy, Done;

   int n_chk = 0;
   int n_bad = 0;
   int cyc = 0;
   int we_errs = 0;
   int last_end = 0;
   logic [7:0]  exp_q[$];
   int          starts_q[$];
   int          ends_q[$];
   logic [15:0] mem[logic [17:0]];
   logic [15:0] rd_p1 = '0;
   logic [15:0] rd_p2 = '0;

   uart_sram_tx_interface #(
      .CLKS_PER_BIT     (CPB),
      .SRAM_READ_LATENCY(LAT)
   ) dut (
      .Clock         (Clock),
      .Resetn        (Resetn),
      .Start         (Start),
      .Abort         (Abort),
      .Base_address  (Base_address),
      .Word_count    (Word_count),
      .SRAM_address  (SRAM_address),
      .SRAM_read_data(SRAM_read_data),
      .SRAM_we_n     (SRAM_we_n),
      .UART_TX_O     (UART_TX_O),
      .Busy          (Busy),
      .Done          (Done)
   );

   always #10 Clock = ~Clock;

   function automatic logic [15:0] mem_rd(input logic [17:0] a);
      if (mem.exists(a)) return mem[a];
      return 16'hFFFF;
   endfunction

   always @(posedge Clock) begin
      cyc   <= cyc + 1;
      rd_p1 <= mem_rd(SRAM_address);
      rd_p2 <= rd_p1;
   end
   assign SRAM_read_data = rd_p2;

   always @(negedge Clock) if (SRAM_we_n !== 1'b1) we_errs++;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push_word(input logic [15:0] w);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
   endtask

   task automatic pulse_start(input logic [17:0] base, input logic [17:0] cnt, output int sc);
      @(posedge Clock);
      #1;
      Base_address = base;
      Word_count   = cnt;
      Start        = 1'b1;
      sc           = cyc;
      @(posedge Clock);
      #1;
      Start = 1'b0;
   endtask

   task automatic wait_done(input int maxc, output int dcyc, output int pulses);
      dcyc   = -1;
      pulses = 0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge Clock);
         if (Done === 1'b1) begin
            if (dcyc < 0) dcyc = cyc;
            pulses++;
         end
         if (dcyc >= 0 && cyc >= dcyc + 20) break;
      end
      if (dcyc < 0) check_val("done_timeout", 32'd0, 32'd1);
   endtask

   // Line decoder: compares every cycle of a frame with the expected waveform
   initial begin : monitor
      logic       prev, has_exp, aborted, lvl;
      logic [7:0] exp_b, got_b;
      int         errs, t0, bidx;
      prev = 1'b1;
      forever begin
         @(negedge Clock);
         if (Resetn && prev && !UART_TX_O) begin
            has_exp = (exp_q.size() > 0);
            exp_b   = 8'h00;
            if (has_exp) exp_b = exp_q.pop_front();
            else         check_val("unexpected_frame", 32'd1, 32'd0);
            t0      = cyc;
            errs    = 0;
            got_b   = '0;
            aborted = 1'b0;
            for (int off = 0; off < int'(10 * CPB); off++) begin
               if (off > 0) @(negedge Clock);
               if (!Resetn) begin
                  aborted = 1'b1;
                  break;
               end
               bidx = off / int'(CPB);
               if (bidx == 0)      lvl = 1'b0;
               else if (bidx == 9) lvl = 1'b1;
               else                lvl = exp_b[bidx-1];
               if (UART_TX_O !== lvl) errs++;
               if (bidx >= 1 && bidx <= 8 && (off % int'(CPB)) == int'(CPB / 2))
                  got_b[bidx-1] = UART_TX_O;
            end
            if (!aborted) begin
               if (has_exp) begin
                  check_val("frame_shape", errs, 0);
                  check_val("frame_byte", got_b, exp_b);
               end
               starts_q.push_back(t0);
               ends_q.push_back(cyc);
               last_end = cyc;
            end
         end
         prev = UART_TX_O;
      end
   end

   initial begin : stim
      int sc, dc, np, dummy;

      repeat (3) @(negedge Clock);
      check_val("rst_addr", SRAM_address, 0);
      check_val("rst_we_n", SRAM_we_n, 1);
      check_val("rst_tx", UART_TX_O, 1);
      check_val("rst_busy", Busy, 0);
      check_val("rst_done", Done, 0);
      Resetn = 1'b1;
      repeat (3) @(negedge Clock);

      // Empty transfer
      pulse_start(18'h00100, 18'd0, sc);
      wait_done(50, dc, np);
      check_val("zero_done_lat", dc - sc, 2);
      check_val("zero_done_pulses", np, 1);
      check_val("zero_addr", SRAM_address, 18'h0);
      check_val("zero_frames", starts_q.size(), 0);

      // Single word
      mem[18'h00010] = 16'hA55A;
      starts_q.delete();
      ends_q.delete();
      push_word(16'hA55A);
      pulse_start(18'h00010, 18'd1, sc);
      check_val("busy_after_start", Busy, 1);
      wait_done(30 * CPB, dc, np);
      check_val("one_frames", starts_q.size(), 2);
      check_val("one_sb_left", exp_q.size(), 0);
      check_val("one_done_lat", dc - last_end, 2);
      check_val("one_done_pulses", np, 1);
      if (starts_q.size() == 2) check_val("one_hilo_gap", starts_q[1] - ends_q[0], 1);

      // Address wrap
      mem[18'h3FFFF] = 16'h1234;
      mem[18'h00000] = 16'hBEEF;
      starts_q.delete();
      ends_q.delete();
      push_word(16'h1234);
      push_word(16'hBEEF);
      pulse_start(18'h3FFFF, 18'd2, sc);
      wait_done(60 * CPB, dc, np);
      check_val("wrap_frames", starts_q.size(), 4);
      check_val("wrap_sb_left", exp_q.size(), 0);
      check_val("wrap_done_lat", dc - last_end, 2);
      if (starts_q.size() == 4) begin
         check_val("wrap_hilo_gap", starts_q[1] - ends_q[0], 1);
         check_val("wrap_word_gap", starts_q[2] - ends_q[1], 1 + (1 + LAT + 1));
      end

      // Abort during first byte of a 3-word transfer
      mem[18'h00040] = 16'hC381;
      mem[18'h00041] = 16'h1111;
      mem[18'h00042] = 16'h2222;
      starts_q.delete();
      ends_q.delete();
      exp_q.push_back(8'hC3);
      pulse_start(18'h00040, 18'd3, sc);
      for (int i = 0; i < 100 && starts_q.size() == 0; i++) begin
         @(negedge Clock);
         if (UART_TX_O == 1'b0) break;
      end
      repeat (3 * CPB) @(negedge Clock);
      Abort = 1'b1;
      wait_done(30 * CPB, dc, np);
      Abort = 1'b0;
      check_val("abort_frames", starts_q.size(), 1);
      check_val("abort_sb_left", exp_q.size(), 0);
      check_val("abort_done_lat", dc - last_end, 2);
      check_val("abort_done_pulses", np, 1);

      // Second Start while busy is ignored
      mem[18'h00050] = 16'h0FF0;
      mem[18'h00060] = 16'h7777;
      starts_q.delete();
      ends_q.delete();
      push_word(16'h0FF0);
      pulse_start(18'h00050, 18'd1, sc);
      repeat (100) @(posedge Clock);
      pulse_start(18'h00060, 18'd5, dummy);
      wait_done(30 * CPB, dc, np);
      check_val("dbl_frames", starts_q.size(), 2);
      check_val("dbl_sb_left", exp_q.size(), 0);
      check_val("dbl_done_lat", dc - last_end, 2);
      check_val("dbl_done_pulses", np, 1);

      // Reset in the middle of a data bit
      mem[18'h00070] = 16'h3C96;
      push_word(16'h3C96);
      pulse_start(18'h00070, 18'd1, sc);
      repeat (5 + 3 * CPB + 200) @(posedge Clock);
      #3;
      Resetn = 1'b0;
      #1;
      check_val("rstmid_tx", UART_TX_O, 1);
      check_val("rstmid_busy", Busy, 0);
      check_val("rstmid_done", Done, 0);
      exp_q.delete();
      repeat (5) @(negedge Clock);
      Resetn = 1'b1;
      starts_q.delete();
      ends_q.delete();
      push_word(16'h3C96);
      pulse_start(18'h00070, 18'd1, sc);
      wait_done(30 * CPB, dc, np);
      check_val("rstmid_frames", starts_q.size(), 2);
      check_val("rstmid_sb_left", exp_q.size(), 0);
      check_val("rstmid_done_lat", dc - last_end, 2);

      check_val("we_n_high", we_errs, 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
